// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: controller states, angle constants and the
// arctangent table in signed 16-bit binary-angle units (16'h8000 = -pi).
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          ANGLE_W = 16;
  localparam logic [15:0] PI      = 16'h8000;
  localparam logic [15:0] HALF_PI = 16'h4000;

  // round(atan(2^-k) * 32768 / pi); the last two entries are defined as 0.
  localparam logic [15:0] ATAN_TABLE [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
    16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005,
    16'h0003, 16'h0001, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent constant lookup, one entry per micro-rotation.
module atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] atan_o
);

  assign atan_o = ATAN_TABLE[idx_i];

endmodule

// File: rtl/cordic_seq.sv
// Sequencer for an iterative CORDIC angle datapath: captures the target
// angle, steps ITERS micro-rotations, then holds done until acknowledged.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int ITERS = 16,  // 1..16
  parameter int WIDTH = 16   // only 16 is supported
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] endangle,
  input  logic [WIDTH-1:0] outreg,
  input  logic             done_ack,
  output logic             ready,
  output logic             load,
  output logic [WIDTH-1:0] endangle_q,
  output logic [WIDTH-1:0] data,
  output logic [3:0]       iter,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

  state_e           state_q, state_d;
  logic [3:0]       iter_q, iter_d;
  logic [WIDTH-1:0] angle_q, angle_d;
  logic [15:0]      atan_val;

  atan_rom u_atan_rom (
    .idx_i  (iter_q),
    .atan_o (atan_val)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      angle_q <= angle_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    angle_d = angle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          angle_d = endangle;
          iter_d  = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (iter_q == LAST_ITER) begin
          iter_d  = '0;
          state_d = ST_DONE;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      ST_DONE: begin
        // A start arriving with the ack is dropped; only the result retires.
        if (done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    busy  = (state_q == ST_ITER);
    done  = (state_q == ST_DONE);
    load  = 1'b0;
    data  = '0;
    iter  = '0;
    dir   = 1'b0;
    if (state_q == ST_ITER) begin
      load = (iter_q == 4'd0);
      data = WIDTH'(atan_val);
      iter = iter_q;
      // Iteration 0 steers from the target itself; later ones from the residual.
      dir  = (iter_q == 4'd0) ? ~angle_q[WIDTH-1] : ~outreg[WIDTH-1];
    end
  end

  assign endangle_q = angle_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Self-checking bench for cordic_seq with a behavioural angle datapath and a
// scoreboard of expected per-iteration controls.
module tb_cordic_seq;

  localparam int N_ITERS = 16;
  localparam logic [15:0] TB_ATAN [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 16'h0000
  };

  typedef struct packed {
    logic [3:0]  it;
    logic        ld;
    logic [15:0] dt;
    logic        dr;
  } exp_t;

  logic        clock, reset_n, start, done_ack;
  logic [15:0] endangle, outreg, endangle_q, data;
  logic        ready, load, dir, busy, done;
  logic [3:0]  iter;

  logic        start4, done_ack4;
  logic [15:0] endangle4, outreg4, endangle_q4, data4;
  logic        ready4, load4, dir4, busy4, done4;
  logic [3:0]  iter4;

  logic [15:0] zreg;
  exp_t        exp_q[$];
  int          pass_cnt, chk_cnt;

  cordic_seq #(.ITERS(N_ITERS), .WIDTH(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .endangle(endangle),
    .outreg(outreg), .done_ack(done_ack), .ready(ready), .load(load),
    .endangle_q(endangle_q), .data(data), .iter(iter), .dir(dir),
    .busy(busy), .done(done)
  );

  cordic_seq #(.ITERS(4), .WIDTH(16)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .endangle(endangle4),
    .outreg(outreg4), .done_ack(done_ack4), .ready(ready4), .load(load4),
    .endangle_q(endangle_q4), .data(data4), .iter(iter4), .dir(dir4),
    .busy(busy4), .done(done4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Angle datapath: rotates the residual toward zero as the controller steers.
  always_ff @(posedge clock) begin
    if (load)      zreg <= dir ? endangle_q - data : endangle_q + data;
    else if (busy) zreg <= dir ? zreg - data : zreg + data;
  end
  assign outreg  = zreg;
  assign outreg4 = 16'h0000;

  task automatic push_op(input logic [15:0] angle, output logic [15:0] zf);
    logic [15:0] z;
    exp_t        e;
    z = angle;
    for (int k = 0; k < N_ITERS; k++) begin
      e.it = 4'(k);
      e.ld = (k == 0);
      e.dt = TB_ATAN[k];
      e.dr = ~z[15];
      z    = e.dr ? z - e.dt : z + e.dt;
      exp_q.push_back(e);
    end
    zf = z;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        chk_cnt++;
        if (busy) begin
          if (exp_q.size() == 0) begin
            $display("FAIL step: busy with no operation pending, iter=%0d", iter);
          end else begin
            e = exp_q.pop_front();
            if ({iter, load, data, dir, ready} !== {e.it, e.ld, e.dt, e.dr, 1'b0})
              $display("FAIL step: iter/load/data/dir/ready got %0d/%b/%h/%b/%b want %0d/%b/%h/%b/0",
                       iter, load, data, dir, ready, e.it, e.ld, e.dt, e.dr);
            else pass_cnt++;
          end
        end else begin
          if ({load, data, iter, dir} !== 22'd0)
            $display("FAIL idle_outs: load/data/iter/dir got %b/%h/%0d/%b want 0/0000/0/0",
                     load, data, iter, dir);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
    chk_cnt++;
    if (!done || n != N_ITERS + 1)
      $display("FAIL latency: done=%b after %0d samples, want done=1 after %0d", done, n, N_ITERS + 1);
    else pass_cnt++;
  endtask

  task automatic check_result(input logic [15:0] zf, input bit chk_res, input string name);
    chk_cnt++;
    if (zreg !== zf) $display("FAIL %s residual: got %h want %h", name, zreg, zf);
    else pass_cnt++;
    if (chk_res) begin
      chk_cnt++;
      if ($signed(zreg) < -2 || $signed(zreg) > 2)
        $display("FAIL %s converge: residual %h, want within +-2 of 0", name, zreg);
      else pass_cnt++;
    end
  endtask

  task automatic ack_done();
    @(posedge clock); #1 done_ack = 1'b1;
    @(posedge clock); #1 done_ack = 1'b0;
    chk_cnt++;
    if (ready !== 1'b1 || done !== 1'b0) $display("FAIL ack: ready/done got %b/%b want 1/0", ready, done);
    else pass_cnt++;
  endtask

  task automatic run_op(input logic [15:0] angle, input bit chk_res, input string name);
    int n;
    logic [15:0] zf;
    @(posedge clock); #1;
    chk_cnt++;
    if (ready !== 1'b1) $display("FAIL %s ready: got %b want 1", name, ready);
    else pass_cnt++;
    start = 1'b1; endangle = angle;
    push_op(angle, zf);
    @(posedge clock); #1;
    start = 1'b0; endangle = 16'h0;
    chk_cnt++;
    if (endangle_q !== angle) $display("FAIL %s capture: endangle_q got %h want %h", name, endangle_q, angle);
    else pass_cnt++;
    wait_done(0, n);
    check_result(zf, chk_res, name);
    ack_done();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; done_ack = 1'b0; endangle = '0;
    start4 = 1'b0; done_ack4 = 1'b0; endangle4 = '0;
    #3;
    chk_cnt++;
    if ({ready, busy, done, load, data, iter, dir, endangle_q} !== {3'b100, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0})
      $display("FAIL reset_vals: rdy/bsy/dn/ld/data/iter/dir/eq got %b%b%b/%b/%h/%0d/%b/%h",
               ready, busy, done, load, data, iter, dir, endangle_q);
    else pass_cnt++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_pos30();
    run_op(16'h1555, 1'b1, "pos30");
  endtask

  task automatic test_neg30();
    run_op(16'hEAAB, 1'b1, "neg30");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_op(16'($urandom_range(0, 16'hFFFF)), 1'b0, "rand");
  endtask

  task automatic test_start_held();
    int n;
    logic [15:0] zf, zf2;
    @(posedge clock); #1;
    start = 1'b1; endangle = 16'h0C00;
    push_op(16'h0C00, zf);
    wait_done(-1, n);
    check_result(zf, 1'b0, "held1");
    repeat (3) begin
      @(negedge clock);
      chk_cnt++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL held_done: done/busy got %b/%b want 1/0", done, busy);
      else pass_cnt++;
    end
    @(posedge clock); #1 done_ack = 1'b1; endangle = 16'hF400;
    @(posedge clock); #1 done_ack = 1'b0;
    chk_cnt++;
    if (ready !== 1'b1 || busy !== 1'b0 || endangle_q !== 16'h0C00)
      $display("FAIL held_ack: ready/busy/endangle_q got %b/%b/%h want 1/0/0c00", ready, busy, endangle_q);
    else pass_cnt++;
    push_op(16'hF400, zf2);
    @(posedge clock); #1 start = 1'b0;
    chk_cnt++;
    if (endangle_q !== 16'hF400) $display("FAIL held_second: endangle_q got %h want f400", endangle_q);
    else pass_cnt++;
    wait_done(0, n);
    check_result(zf2, 1'b0, "held2");
    ack_done();
  endtask

  task automatic test_ack_withheld();
    int n;
    logic [15:0] zf;
    logic [41:0] snap;
    @(posedge clock); #1 done_ack = 1'b1;
    @(posedge clock); #1 done_ack = 1'b0;
    chk_cnt++;
    if (ready !== 1'b1 || done !== 1'b0) $display("FAIL idle_ack: ready/done got %b/%b want 1/0", ready, done);
    else pass_cnt++;
    start = 1'b1; endangle = 16'h2AAA;
    push_op(16'h2AAA, zf);
    @(posedge clock); #1 start = 1'b0; done_ack = 1'b1;
    @(negedge clock);
    @(posedge clock); #1 done_ack = 1'b0;
    wait_done(1, n);
    check_result(zf, 1'b0, "withheld");
    snap = {ready, busy, done, load, data, iter, dir, endangle_q};
    repeat (10) begin
      @(negedge clock);
      chk_cnt++;
      if ({ready, busy, done, load, data, iter, dir, endangle_q} !== snap || done !== 1'b1)
        $display("FAIL withheld_stable: outputs %h want %h", {ready, busy, done, load, data, iter, dir, endangle_q}, snap);
      else pass_cnt++;
    end
    @(posedge clock); #1 done_ack = 1'b1; start = 1'b1; endangle = 16'h1111;
    @(posedge clock); #1 done_ack = 1'b0; start = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if (ready !== 1'b1 || busy !== 1'b0 || endangle_q !== 16'h2AAA)
      $display("FAIL ack_start: ready/busy/endangle_q got %b/%b/%h want 1/0/2aaa", ready, busy, endangle_q);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [15:0] zf;
    @(posedge clock); #1 start = 1'b1; endangle = 16'h3000;
    push_op(16'h3000, zf);
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(busy && iter == 4'd7) && n < 30);
    chk_cnt++;
    if (!(busy && iter == 4'd7)) $display("FAIL reach_iter7: busy/iter got %b/%0d want 1/7", busy, iter);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk_cnt++;
    if ({ready, busy, done, load, data, iter, dir, endangle_q} !== {3'b100, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0})
      $display("FAIL async_reset: rdy/bsy/dn/ld/data/iter/dir/eq got %b%b%b/%b/%h/%0d/%b/%h",
               ready, busy, done, load, data, iter, dir, endangle_q);
    else pass_cnt++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (30) begin
      @(negedge clock);
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1)
        $display("FAIL post_reset: done/busy/ready got %b/%b/%b want 0/0/1", done, busy, ready);
      else pass_cnt++;
    end
    run_op(16'h1555, 1'b1, "after_reset");
  endtask

  task automatic test_iters4();
    @(posedge clock); #1;
    chk_cnt++;
    if (ready4 !== 1'b1) $display("FAIL i4_ready: got %b want 1", ready4);
    else pass_cnt++;
    start4 = 1'b1; endangle4 = 16'h1555;
    @(posedge clock); #1 start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk_cnt++;
      if (busy4 !== 1'b1 || iter4 !== 4'(k) || load4 !== (k == 0) || data4 !== TB_ATAN[k])
        $display("FAIL i4_step: busy/iter/load/data got %b/%0d/%b/%h want 1/%0d/%b/%h",
                 busy4, iter4, load4, data4, k, (k == 0), TB_ATAN[k]);
      else pass_cnt++;
    end
    @(negedge clock);
    chk_cnt++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) $display("FAIL i4_done: done/busy got %b/%b want 1/0", done4, busy4);
    else pass_cnt++;
    @(posedge clock); #1 done_ack4 = 1'b1;
    @(posedge clock); #1 done_ack4 = 1'b0;
    chk_cnt++;
    if (ready4 !== 1'b1 || done4 !== 1'b0) $display("FAIL i4_ack: ready/done got %b/%b want 1/0", ready4, done4);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    fork monitor(); join_none
    test_pos30();
    test_neg30();
    test_random();
    test_start_held();
    test_ack_withheld();
    test_reset_mid();
    test_iters4();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d expected steps never seen, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
